// File: rtl/load_store_unit_if.sv
// Bundle of the load/store unit's execute, memory and writeback signals.
//   Execute side : ex_valid, ex_ready, ALUResult, WriteData, MemWrite, Funct3, Rd
//   Memory side  : mem_req, mem_we, mem_addr, mem_be, mem_wdata, mem_ack, mem_rdata
//   Writeback    : wb_valid, wb_we, RdOut, ReadData, mem_err
// Modport master is the load/store unit; modport slave is its environment
// (execute stage, memory and writeback together).
interface load_store_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ex_valid;
  logic                  ex_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWrite;
  logic [2:0]            Funct3;
  logic [4:0]            Rd;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  wb_valid;
  logic                  wb_we;
  logic [4:0]            RdOut;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  mem_err;

  modport master (
    input  ex_valid, ALUResult, WriteData, MemWrite, Funct3, Rd, mem_ack, mem_rdata,
    output ex_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output wb_valid, wb_we, RdOut, ReadData, mem_err
  );

  modport slave (
    output ex_valid, ALUResult, WriteData, MemWrite, Funct3, Rd, mem_ack, mem_rdata,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  wb_valid, wb_we, RdOut, ReadData, mem_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory operation at a time from execute, issues a
// single word-aligned request to memory, and reports one writeback pulse.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : load_store_unit_if.master (execute, memory and writeback signals)
// Illegal or misaligned accesses skip memory and report mem_err directly.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [4:0]            rd_q;
  logic                  err_q;

  logic                  accept;
  logic                  illegal;
  logic                  misaligned;
  logic                  busy;
  logic                  done;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] load_ext;

  assign accept = (state_q == StIdle) && bus.ex_valid;
  assign busy   = (state_q == StBusy);
  assign done   = (state_q == StDone);

  // Error classification on the live execute inputs; result is latched on accept.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (bus.Funct3)
      3'b000: ;
      3'b001: misaligned = bus.ALUResult[0];
      3'b010: misaligned = |bus.ALUResult[1:0];
      3'b100: illegal    = bus.MemWrite;
      3'b101: begin
        illegal    = bus.MemWrite;
        misaligned = bus.ALUResult[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.ex_valid) state_d = (illegal || misaligned) ? StDone : StBusy;
      StBusy: if (bus.mem_ack) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Store lane placement from the latched access.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << addr_q[1:0];
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection and extension of the word returned with mem_ack.
  always_comb begin
    rd_byte  = bus.mem_rdata[7:0];
    rd_half  = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_ext = bus.mem_rdata;
    case (addr_q[1:0])
      2'b00: rd_byte = bus.mem_rdata[7:0];
      2'b01: rd_byte = bus.mem_rdata[15:8];
      2'b10: rd_byte = bus.mem_rdata[23:16];
      default: rd_byte = bus.mem_rdata[31:24];
    endcase
    case (funct3_q)
      3'b000: load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001: load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100: load_ext = {24'd0, rd_byte};
      3'b101: load_ext = {16'd0, rd_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      rd_q     <= 5'd0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= bus.ALUResult;
        wdata_q  <= bus.WriteData;
        we_q     <= bus.MemWrite;
        funct3_q <= bus.Funct3;
        rd_q     <= bus.Rd;
        err_q    <= illegal || misaligned;
        // Stores and faulted accesses report zero read data.
        rdata_q  <= '0;
      end else if (busy && bus.mem_ack && !we_q) begin
        rdata_q <= load_ext;
      end
    end
  end

  // Memory outputs are only driven while the request is outstanding.
  assign bus.ex_ready  = (state_q == StIdle);
  assign bus.mem_req   = busy;
  assign bus.mem_we    = busy && we_q;
  assign bus.mem_addr  = busy ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_be    = busy ? be : 4'b0000;
  assign bus.mem_wdata = busy ? wdata_rep : '0;

  assign bus.wb_valid  = done;
  assign bus.wb_we     = done && !we_q && !err_q && (rd_q != 5'd0);
  assign bus.RdOut     = rd_q;
  assign bus.ReadData  = rdata_q;
  assign bus.mem_err   = done && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: expected writeback records are queued
// when an access is issued and compared when the unit reports completion.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_WIDTH(32)) bus ();

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        err;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        unstable;
  } mem_t;

  wb_t sb[$];
  int  errors = 0;
  int  checks = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Issue one access starting at a negedge with the unit idle. Scrambles the
  // execute inputs after acceptance, answers the request after ack_after BUSY
  // cycles, and returns what the unit reported. lat counts cycles from accept.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, input logic [2:0] f3, input logic [4:0] rd,
                           input int ack_after, input logic [31:0] rdata,
                           output bit seen, output wb_t wb, output bit wb_again,
                           output int lat, output int req_cycles, output mem_t mem);
    int guard;
    seen = 1'b0; wb = '0; wb_again = 1'b0; lat = 0; req_cycles = 0; mem = '0; guard = 0;
    bus.ex_valid  = 1'b1;
    bus.ALUResult = addr;
    bus.WriteData = wdata;
    bus.MemWrite  = we;
    bus.Funct3    = f3;
    bus.Rd        = rd;
    while (!bus.ex_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    bus.ex_valid  = 1'b0;
    bus.ALUResult = $urandom;
    bus.WriteData = $urandom;
    bus.MemWrite  = 1'($urandom_range(0, 1));
    bus.Funct3    = 3'($urandom_range(0, 7));
    bus.Rd        = 5'($urandom_range(0, 31));
    lat = 1;
    while (lat < 40) begin
      if (bus.wb_valid) begin
        seen    = 1'b1;
        wb.err  = bus.mem_err;
        wb.we   = bus.wb_we;
        wb.rd   = bus.RdOut;
        wb.data = bus.ReadData;
        break;
      end
      if (bus.mem_req) begin
        if (req_cycles == 0) begin
          mem.we = bus.mem_we; mem.addr = bus.mem_addr;
          mem.be = bus.mem_be; mem.wdata = bus.mem_wdata;
        end else if ({mem.we, mem.addr, mem.be, mem.wdata} !==
                     {bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}) begin
          mem.unstable = 1'b1;
        end
        req_cycles++;
        bus.mem_ack   = (req_cycles >= ack_after);
        bus.mem_rdata = bus.mem_ack ? rdata : $urandom;
      end else begin
        bus.mem_ack = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.mem_ack = 1'b0;
    @(negedge clk);
    wb_again = bus.wb_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ALUResult = '0; bus.WriteData = '0; bus.MemWrite = 1'b0;
    bus.Funct3 = 3'b000; bus.Rd = 5'd0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.ex_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ex_ready: got %b want 1", bus.ex_ready);
    end
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_mem_outputs: got req=%b we=%b addr=%h be=%b wdata=%h want 0",
                         bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata);
    end
    checks++;
    if ({bus.wb_valid, bus.wb_we, bus.RdOut, bus.ReadData, bus.mem_err} !== '0) begin
      errors++; $display("FAIL reset_wb_outputs: got v=%b we=%b rd=%0d data=%h err=%b want 0",
                         bus.wb_valid, bus.wb_we, bus.RdOut, bus.ReadData, bus.mem_err);
    end
  endtask

  task automatic test_lw();
    bit seen, again; wb_t wb, e; int lat, reqc; mem_t mem;
    sb.push_back('{err: 1'b0, we: 1'b1, rd: 5'd5, data: 32'hDEADBEEF});
    do_access(32'h100, 32'h0, 1'b0, 3'b010, 5'd5, 2, 32'hDEADBEEF,
              seen, wb, again, lat, reqc, mem);
    e = sb.pop_front();
    checks++;
    if (!seen || wb !== e) begin
      errors++; $display("FAIL lw_wb: seen=%b got %h want %h", seen, wb, e);
    end
    checks++;
    if ({mem.we, mem.addr, mem.be, mem.unstable} !== {1'b0, 32'h100, 4'b1111, 1'b0}) begin
      errors++; $display("FAIL lw_mem: got we=%b addr=%h be=%b unstable=%b want 0 100 1111 0",
                         mem.we, mem.addr, mem.be, mem.unstable);
    end
    checks++;
    if (lat !== 3 || reqc !== 2 || again !== 1'b0) begin
      errors++; $display("FAIL lw_timing: got lat=%0d req=%0d wb_again=%b want 3 2 0",
                         lat, reqc, again);
    end
  endtask

  task automatic test_lb_lbu();
    bit seen, again; wb_t wb, e; int lat, reqc; mem_t mem;
    sb.push_back('{err: 1'b0, we: 1'b1, rd: 5'd9, data: 32'hFFFFFF80});
    do_access(32'h103, 32'h0, 1'b0, 3'b000, 5'd9, 1, 32'h80FF0000,
              seen, wb, again, lat, reqc, mem);
    e = sb.pop_front();
    checks++;
    if (!seen || wb !== e) begin
      errors++; $display("FAIL lb_wb: seen=%b got %h want %h", seen, wb, e);
    end
    checks++;
    if ({mem.addr, mem.be} !== {32'h100, 4'b1000}) begin
      errors++; $display("FAIL lb_mem: got addr=%h be=%b want 100 1000", mem.addr, mem.be);
    end
    sb.push_back('{err: 1'b0, we: 1'b1, rd: 5'd9, data: 32'h00000080});
    do_access(32'h103, 32'h0, 1'b0, 3'b100, 5'd9, 3, 32'h80FF0000,
              seen, wb, again, lat, reqc, mem);
    e = sb.pop_front();
    checks++;
    if (!seen || wb !== e) begin
      errors++; $display("FAIL lbu_wb: seen=%b got %h want %h", seen, wb, e);
    end
    // Upper halfword, signed and unsigned.
    sb.push_back('{err: 1'b0, we: 1'b1, rd: 5'd3, data: 32'hFFFF9876});
    do_access(32'h42, 32'h0, 1'b0, 3'b001, 5'd3, 1, 32'h98761234,
              seen, wb, again, lat, reqc, mem);
    e = sb.pop_front();
    checks++;
    if (!seen || wb !== e) begin
      errors++; $display("FAIL lh_wb: seen=%b got %h want %h", seen, wb, e);
    end
    sb.push_back('{err: 1'b0, we: 1'b1, rd: 5'd3, data: 32'h00009876});
    do_access(32'h42, 32'h0, 1'b0, 3'b101, 5'd3, 1, 32'h98761234,
              seen, wb, again, lat, reqc, mem);
    e = sb.pop_front();
    checks++;
    if (!seen || wb !== e) begin
      errors++; $display("FAIL lhu_wb: seen=%b got %h want %h", seen, wb, e);
    end
  endtask

  task automatic test_stores();
    bit seen, again; wb_t wb, e; int lat, reqc; mem_t mem;
    sb.push_back('{err: 1'b0, we: 1'b0, rd: 5'd4, data: 32'h0});
    do_access(32'h202, 32'h1234ABCD, 1'b1, 3'b001, 5'd4, 3, 32'hFFFFFFFF,
              seen, wb, again, lat, reqc, mem);
    e = sb.pop_front();
    checks++;
    if (!seen || wb !== e) begin
      errors++; $display("FAIL sh_wb: seen=%b got %h want %h", seen, wb, e);
    end
    checks++;
    if (mem !== {1'b1, 32'h200, 4'b1100, 32'hABCDABCD, 1'b0}) begin
      errors++; $display("FAIL sh_mem: got we=%b addr=%h be=%b wdata=%h unstable=%b",
                         mem.we, mem.addr, mem.be, mem.wdata, mem.unstable);
    end
    sb.push_back('{err: 1'b0, we: 1'b0, rd: 5'd0, data: 32'h0});
    do_access(32'h301, 32'hCAFE005A, 1'b1, 3'b000, 5'd0, 1, 32'h0,
              seen, wb, again, lat, reqc, mem);
    e = sb.pop_front();
    checks++;
    if (!seen || wb !== e || mem !== {1'b1, 32'h300, 4'b0010, 32'h5A5A5A5A, 1'b0}) begin
      errors++; $display("FAIL sb_store: seen=%b wb=%h want %h be=%b wdata=%h",
                         seen, wb, e, mem.be, mem.wdata);
    end
    sb.push_back('{err: 1'b0, we: 1'b0, rd: 5'd1, data: 32'h0});
    do_access(32'h404, 32'h89ABCDEF, 1'b1, 3'b010, 5'd1, 2, 32'h0,
              seen, wb, again, lat, reqc, mem);
    e = sb.pop_front();
    checks++;
    if (!seen || wb !== e || mem !== {1'b1, 32'h404, 4'b1111, 32'h89ABCDEF, 1'b0}) begin
      errors++; $display("FAIL sw_store: seen=%b wb=%h want %h be=%b wdata=%h",
                         seen, wb, e, mem.be, mem.wdata);
    end
  endtask

  task automatic test_errors();
    bit seen, again; wb_t wb, e; int lat, reqc; mem_t mem;
    sb.push_back('{err: 1'b1, we: 1'b0, rd: 5'd6, data: 32'h0});
    do_access(32'h102, 32'h0, 1'b0, 3'b010, 5'd6, 1, 32'h12345678,
              seen, wb, again, lat, reqc, mem);
    e = sb.pop_front();
    checks++;
    if (!seen || wb !== e || reqc !== 0 || lat !== 1) begin
      errors++; $display("FAIL lw_misaligned: seen=%b wb=%h want %h req=%0d lat=%0d want 0 1",
                         seen, wb, e, reqc, lat);
    end
    sb.push_back('{err: 1'b1, we: 1'b0, rd: 5'd6, data: 32'h0});
    do_access(32'h100, 32'h0, 1'b0, 3'b011, 5'd6, 1, 32'h12345678,
              seen, wb, again, lat, reqc, mem);
    e = sb.pop_front();
    checks++;
    if (!seen || wb !== e || reqc !== 0 || lat !== 1) begin
      errors++; $display("FAIL funct3_011: seen=%b wb=%h want %h req=%0d lat=%0d want 0 1",
                         seen, wb, e, reqc, lat);
    end
    sb.push_back('{err: 1'b1, we: 1'b0, rd: 5'd2, data: 32'h0});
    do_access(32'h100, 32'h55, 1'b1, 3'b100, 5'd2, 1, 32'h0,
              seen, wb, again, lat, reqc, mem);
    e = sb.pop_front();
    checks++;
    if (!seen || wb !== e || reqc !== 0) begin
      errors++; $display("FAIL store_bu_illegal: seen=%b wb=%h want %h req=%0d want 0",
                         seen, wb, e, reqc);
    end
    sb.push_back('{err: 1'b1, we: 1'b0, rd: 5'd2, data: 32'h0});
    do_access(32'h105, 32'h0, 1'b0, 3'b101, 5'd2, 1, 32'h0,
              seen, wb, again, lat, reqc, mem);
    e = sb.pop_front();
    checks++;
    if (!seen || wb !== e || reqc !== 0) begin
      errors++; $display("FAIL lhu_misaligned: seen=%b wb=%h want %h req=%0d want 0",
                         seen, wb, e, reqc);
    end
  endtask

  task automatic test_rd_zero();
    bit seen, again; wb_t wb, e; int lat, reqc; mem_t mem;
    sb.push_back('{err: 1'b0, we: 1'b0, rd: 5'd0, data: 32'h11223344});
    do_access(32'h80, 32'h0, 1'b0, 3'b010, 5'd0, 1, 32'h11223344,
              seen, wb, again, lat, reqc, mem);
    e = sb.pop_front();
    checks++;
    if (!seen || wb !== e || reqc !== 1) begin
      errors++; $display("FAIL rd_zero: seen=%b wb=%h want %h req=%0d want 1", seen, wb, e, reqc);
    end
  endtask

  task automatic test_back_to_back();
    wb_t e;
    bus.ex_valid = 1'b1; bus.ALUResult = 32'h300; bus.WriteData = 32'h0BADF00D;
    bus.MemWrite = 1'b1; bus.Funct3 = 3'b010; bus.Rd = 5'd8;
    sb.push_back('{err: 1'b0, we: 1'b0, rd: 5'd8, data: 32'h0});
    sb.push_back('{err: 1'b0, we: 1'b1, rd: 5'd7, data: 32'hFFFF8001});
    @(negedge clk);
    // Op 2 presented while op 1 is busy; op 1 must keep its latched fields.
    bus.ALUResult = 32'h402; bus.WriteData = 32'h0; bus.MemWrite = 1'b0;
    bus.Funct3 = 3'b001; bus.Rd = 5'd7;
    checks++;
    if (bus.ex_ready !== 1'b0 || bus.mem_req !== 1'b1 ||
        {bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h300, 32'h0BADF00D}) begin
      errors++; $display("FAIL b2b_busy: ready=%b req=%b we=%b addr=%h wdata=%h",
                         bus.ex_ready, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    e = sb.pop_front();
    checks++;
    if (bus.ex_ready !== 1'b0 || bus.wb_valid !== 1'b1 ||
        {bus.mem_err, bus.wb_we, bus.RdOut, bus.ReadData} !== e) begin
      errors++; $display("FAIL b2b_done1: ready=%b valid=%b got %h want %h", bus.ex_ready,
                         bus.wb_valid, {bus.mem_err, bus.wb_we, bus.RdOut, bus.ReadData}, e);
    end
    @(negedge clk);
    checks++;
    if (bus.ex_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: ready=%b valid=%b want 1 0", bus.ex_ready, bus.wb_valid);
    end
    @(negedge clk);
    bus.ex_valid = 1'b0;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be} !== {1'b1, 1'b0, 32'h400, 4'b1100})
    begin
      errors++; $display("FAIL b2b_second_req: req=%b we=%b addr=%h be=%b want 1 0 400 1100",
                         bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80015555;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    e = sb.pop_front();
    checks++;
    if (bus.wb_valid !== 1'b1 || {bus.mem_err, bus.wb_we, bus.RdOut, bus.ReadData} !== e) begin
      errors++; $display("FAIL b2b_done2: valid=%b got %h want %h", bus.wb_valid,
                         {bus.mem_err, bus.wb_we, bus.RdOut, bus.ReadData}, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bus.ex_valid = 1'b1; bus.ALUResult = 32'h500; bus.MemWrite = 1'b0;
    bus.Funct3 = 3'b010; bus.Rd = 5'd11;
    @(negedge clk);
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL abort_busy: mem_req got %b want 1", bus.mem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.ex_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL abort_after_reset: req=%b ready=%b valid=%b want 0 1 0",
                         bus.mem_req, bus.ex_ready, bus.wb_valid);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.ex_ready !== 1'b1 || bus.ReadData !== 32'h0) begin
      errors++; $display("FAIL abort_stray_ack: valid=%b ready=%b data=%h want 0 1 0",
                         bus.wb_valid, bus.ex_ready, bus.ReadData);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_stores();
    test_errors();
    test_rd_zero();
    test_back_to_back();
    test_reset_abort();
    test_lw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data and address width; only 32 is supported.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ex_valid  in  1  execute stage presents a memory operation.
REQ-006 ex_ready  out  1  unit can accept an operation this cycle.
REQ-007 ALUResult  in  32  effective byte address from the ALU.
REQ-008 WriteData  in  32  store data, rs2 value.
REQ-009 MemWrite  in  1  1 = store, 0 = load.
REQ-010 Funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 Rd  in  5  load destination register.
REQ-012 mem_req  out  1  memory request, held until acknowledged.
REQ-013 mem_we  out  1  request is a write.
REQ-014 mem_addr  out  32  word-aligned address, ALUResult with bits [1:0] forced to 0.
REQ-015 mem_be  out  4  byte enables.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_ack  in  1  memory completion; carries read data for loads.
REQ-018 mem_rdata  in  32  read word, valid when mem_ack=1.
REQ-019 wb_valid  out  1  one-cycle completion pulse to writeback.
REQ-020 wb_we  out  1  writeback should write RdOut (load, no error, RdOut!=0).
REQ-021 RdOut  out  5  latched Rd.
REQ-022 ReadData  out  32  extended load result.
REQ-023 mem_err  out  1  misaligned or illegal access, valid with wb_valid.

Function
REQ-024 The FSM SHALL have three states:
  - IDLE: waiting for an operation.
  - BUSY: request outstanding.
  - DONE: completion being reported.
REQ-025 ex_ready SHALL equal 1 only in IDLE; an operation is accepted when ex_valid=1 and ex_ready=1.
REQ-026 On acceptance, the block SHALL latch address, data, MemWrite, Funct3 and Rd; later input changes are ignored until the next acceptance.
REQ-027 The error classes SHALL be:
  - Illegal: Funct3 011, 110 or 111; also store with Funct3 100 or 101.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=00.
REQ-028 An accepted access that is illegal or misaligned SHALL go IDLE->DONE without asserting mem_req, with mem_err=1, ReadData=0 and wb_we=0.
REQ-029 An accepted legal access SHALL go IDLE->BUSY; mem_req SHALL be 1 in every BUSY cycle and 0 in all other states.
REQ-030 In BUSY, mem_ack=1 SHALL cause BUSY->DONE; mem_ack outside BUSY SHALL be ignored.
REQ-031 DONE SHALL last exactly one cycle, with wb_valid=1, then return to IDLE; the minimum round trip is 3 cycles (accept, ack, report).
REQ-032 Byte enables and store data SHALL be:
  - B: mem_be=0001<<addr[1:0], mem_wdata={4{WriteData[7:0]}}.
  - H: mem_be=0011<<addr[1:0], mem_wdata={2{WriteData[15:0]}}.
  - W: mem_be=1111, mem_wdata=WriteData.
REQ-033 Loads SHALL select the byte (addr[1:0]) or halfword (addr[1]) lane of mem_rdata, captured on the ack cycle.
REQ-034 Loads SHALL sign-extend for B/H, zero-extend for BU/HU, and pass the word unchanged for W.
REQ-035 A store SHALL complete with wb_valid=1, wb_we=0, ReadData=0, mem_err=0.
REQ-036 mem_we, mem_addr, mem_be and mem_wdata SHALL stay stable for the whole of BUSY.
REQ-037 A load with Rd=0 SHALL still perform the memory access, with wb_we=0.

Reset
REQ-038 rst=1 SHALL force IDLE on the next edge, regardless of state, and discard any outstanding request.
REQ-039 After reset, all outputs SHALL be 0 except ex_ready=1.
REQ-040 An ack arriving in the cycle after a reset that aborted BUSY SHALL be ignored.

Verification
REQ-041 LW at 0x100, mem_rdata=0xDEADBEEF, ack after 2 BUSY cycles -> mem_addr=0x100, mem_be=1111, wb_valid exactly one cycle later, ReadData=0xDEADBEEF, wb_we=1.
REQ-042 LB at 0x103, mem_rdata=0x80FF0000 -> ReadData=0xFFFFFF80; the same access as LBU -> ReadData=0x00000080.
REQ-043 SH at 0x202, WriteData=0x1234ABCD -> mem_we=1, mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD; completion with wb_we=0.
REQ-044 LW at 0x102 -> mem_req never 1, wb_valid 1 cycle after accept, mem_err=1; Funct3=011 gives the same response.
REQ-045 Back-to-back ex_valid held high -> ex_ready=0 during BUSY/DONE; the second operation is accepted in the first IDLE cycle after DONE.
REQ-046 rst asserted in the 2nd BUSY cycle, ack in the next cycle -> mem_req=0, no wb_valid, ex_ready=1 after the reset edge.
